stft_framer: RTL and testbench

STFT_FRAMER -- requirements
Module: stft_framer

---
 rtl/stft_framer.sv | 162 ++++++++++++++++
 tb/tb_stft_framer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/stft_framer.sv
// Overlapping-frame STFT framer: buffers a real sample stream in a 2*FRAME_LEN circular RAM and replays
//   FRAME_LEN-sample frames advancing by HOP, real in the low half and zero imaginary in the high half.
// Latency: first beat of a frame appears 2 cycles after FRAME_LEN samples are buffered; 1 beat/cycle after that.
// Backpressure: input stalls (tready low) while the RAM holds 2*FRAME_LEN samples; output holds beat under m tready low.
//
// Ports:
//   aclk, reset            : single rising-edge clock, synchronous active-high reset
//   s_axis_data_*          : AXI-stream sample input (tdata signed real, DATA_W bits)
//   m_axis_data_*          : AXI-stream complex output {imag=0, real=sample}, tlast on the final beat of a frame
//   m_axis_data_tuser      : {frame count, beat index}; present only when STFT_FRAMER_TUSER_EN is defined
module stft_framer #(
  parameter int DATA_W    = 24,
  parameter int FRAME_LEN = 1024,
  parameter int HOP       = 256
) (
  input  logic                  aclk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     s_axis_data_tdata,
  input  logic                  s_axis_data_tvalid,
  output logic                  s_axis_data_tready,
  output logic [2*DATA_W-1:0]   m_axis_data_tdata,
  output logic                  m_axis_data_tvalid,
  input  logic                  m_axis_data_tready,
`ifdef STFT_FRAMER_TUSER_EN
  output logic [15:0]           m_axis_data_tuser,
`endif
  output logic                  m_axis_data_tlast
);

  localparam int IDX_W = $clog2(FRAME_LEN);
  localparam int PTR_W = IDX_W + 1;          // addresses 2*FRAME_LEN entries, wraps naturally
  localparam int OCC_W = PTR_W + 1;          // occupancy needs to reach 2*FRAME_LEN inclusive

  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(2 * FRAME_LEN);
  localparam logic [OCC_W-1:0] OCC_FRAME = OCC_W'(FRAME_LEN);
  localparam logic [OCC_W-1:0] OCC_HOP   = OCC_W'(HOP);
  localparam logic [PTR_W-1:0] PTR_HOP   = PTR_W'(HOP);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(FRAME_LEN - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EMIT   = 2'd1;
  localparam logic [1:0] ST_RETIRE = 2'd2;

  logic [DATA_W-1:0] mem [2*FRAME_LEN];

  logic [PTR_W-1:0]  wp_q, wp_d, fs_q, fs_d;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              issued_q, issued_d;     // every beat of the current frame has been read out of the RAM
  logic              out_vld_q, out_vld_d;
  logic              out_last_q, out_last_d;
  logic [DATA_W-1:0] out_dat_q, out_dat_d;
`ifdef STFT_FRAMER_TUSER_EN
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic [15-IDX_W:0] frame_cnt_q, frame_cnt_d;
`endif

  logic             s_rdy, wr_en, m_hs, out_free, rd_en, retire;
  logic [PTR_W-1:0] rd_addr;

  // tready is forced low while reset is asserted, and comes up as soon as occupancy has been cleared
  assign s_rdy    = !reset && (occ_q < OCC_FULL);
  assign wr_en    = s_axis_data_tvalid && s_rdy;
  assign m_hs     = out_vld_q && m_axis_data_tready;
  // The output register doubles as the RAM read register; refill it whenever it empties this cycle,
  // which gives back-to-back beats while downstream keeps tready high.
  assign out_free = !out_vld_q || m_axis_data_tready;
  assign rd_en    = (state_q == ST_EMIT) && !issued_q && out_free;
  assign rd_addr  = fs_q + PTR_W'(idx_q);
  assign retire   = (state_q == ST_RETIRE);

  always_comb begin
    wp_d       = wr_en ? wp_q + 1'b1 : wp_q;
    fs_d       = retire ? fs_q + PTR_HOP : fs_q;
    occ_d      = occ_q + OCC_W'(wr_en) - (retire ? OCC_HOP : '0);
    state_d    = state_q;
    idx_d      = idx_q;
    issued_d   = issued_q;
    out_vld_d  = out_vld_q;
    out_last_d = out_last_q;
    out_dat_d  = out_dat_q;
`ifdef STFT_FRAMER_TUSER_EN
    out_idx_d   = out_idx_q;
    frame_cnt_d = retire ? frame_cnt_q + 1'b1 : frame_cnt_q;
`endif

    case (state_q)
      ST_IDLE:   if (occ_q >= OCC_FRAME) state_d = ST_EMIT;
      ST_EMIT:   if (m_hs && out_last_q) state_d = ST_RETIRE;
      ST_RETIRE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    if (rd_en) begin
      idx_d      = idx_q + 1'b1;
      issued_d   = (idx_q == IDX_LAST);
      out_vld_d  = 1'b1;
      out_last_d = (idx_q == IDX_LAST);
      out_dat_d  = mem[rd_addr];
`ifdef STFT_FRAMER_TUSER_EN
      out_idx_d  = idx_q;
`endif
    end else if (m_axis_data_tready) begin
      out_vld_d  = 1'b0;
      out_last_d = 1'b0;
    end

    if (retire) begin
      idx_d    = '0;
      issued_d = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (reset) begin
      wp_q       <= '0;
      fs_q       <= '0;
      occ_q      <= '0;
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      issued_q   <= 1'b0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_dat_q  <= '0;
`ifdef STFT_FRAMER_TUSER_EN
      out_idx_q   <= '0;
      frame_cnt_q <= '0;
`endif
    end else begin
      wp_q       <= wp_d;
      fs_q       <= fs_d;
      occ_q      <= occ_d;
      state_q    <= state_d;
      idx_q      <= idx_d;
      issued_q   <= issued_d;
      out_vld_q  <= out_vld_d;
      out_last_q <= out_last_d;
      out_dat_q  <= out_dat_d;
`ifdef STFT_FRAMER_TUSER_EN
      out_idx_q   <= out_idx_d;
      frame_cnt_q <= frame_cnt_d;
`endif
    end
  end

  // Sample storage is not reset; the pointers alone define which entries are live.
  // wr_en is only true when occupancy < 2*FRAME_LEN, so unread frame samples are never overwritten.
  always_ff @(posedge aclk) begin
    if (wr_en) mem[wp_q] <= s_axis_data_tdata;
  end

  assign s_axis_data_tready = s_rdy;
  // Outputs are masked during reset so they read zero even in the first cycle reset is held
  assign m_axis_data_tvalid = out_vld_q && !reset;
  assign m_axis_data_tlast  = out_last_q && !reset;
  assign m_axis_data_tdata  = reset ? '0 : {{DATA_W{1'b0}}, out_dat_q};
`ifdef STFT_FRAMER_TUSER_EN
  assign m_axis_data_tuser  = reset ? '0 : {frame_cnt_q, out_idx_q};
`endif

endmodule

// File: tb/tb_stft_framer.sv
// Directed bench for stft_framer at DATA_W=24, FRAME_LEN=8, HOP=4.
// Inputs change on the falling edge; outputs are sampled 1ns later, so every recorded handshake is the
// one that completes on the following rising edge.
module tb_stft_framer;

  logic        aclk = 1'b0;
  logic        reset;
  logic [23:0] s_tdata;
  logic        s_tvalid, s_tready;
  logic [47:0] m_tdata;
  logic        m_tvalid, m_tready, m_tlast;
`ifdef STFT_FRAMER_TUSER_EN
  logic [15:0] m_tuser;
  logic [15:0] beat_user [$];
`endif

  always #5 aclk = ~aclk;

  stft_framer #(.DATA_W(24), .FRAME_LEN(8), .HOP(4)) dut (
    .aclk               (aclk),
    .reset              (reset),
    .s_axis_data_tdata  (s_tdata),
    .s_axis_data_tvalid (s_tvalid),
    .s_axis_data_tready (s_tready),
    .m_axis_data_tdata  (m_tdata),
    .m_axis_data_tvalid (m_tvalid),
    .m_axis_data_tready (m_tready),
`ifdef STFT_FRAMER_TUSER_EN
    .m_axis_data_tuser  (m_tuser),
`endif
    .m_axis_data_tlast  (m_tlast)
  );

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc, src_idx, tr_mode, r;
  logic        rst_drive;
  logic [23:0] src_q [$];
  logic [47:0] beat_dat [$];
  logic        beat_last [$];
  int          beat_cyc [$];
  int          acc_cyc [$];
  logic        stall_pend, held_last;
  logic [47:0] held_dat;
  logic        smp_vld, smp_last, smp_srdy;
  logic [47:0] smp_dat;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [47:0] bdat(input int i);
    return (i < beat_dat.size()) ? beat_dat[i] : 48'hx;
  endfunction

  function automatic logic blast(input int i);
    return (i < beat_last.size()) ? beat_last[i] : 1'bx;
  endfunction

  function automatic int bcyc(input int i);
    return (i < beat_cyc.size()) ? beat_cyc[i] : -1;
  endfunction

  function automatic int acyc(input int i);
    return (i < acc_cyc.size()) ? acc_cyc[i] : -1;
  endfunction

  // One clock cycle: drive inputs, sample outputs, log handshakes, check stall stability
  task automatic do_cycle();
    @(negedge aclk);
    reset    = rst_drive;
    s_tvalid = (src_idx < src_q.size());
    s_tdata  = '0;
    if (s_tvalid) s_tdata = src_q[src_idx];
    case (tr_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = (cyc % 2 == 0);
      default: m_tready = 1'b0;
    endcase
    #1;
    smp_vld  = m_tvalid;
    smp_last = m_tlast;
    smp_srdy = s_tready;
    smp_dat  = m_tdata;
    if (stall_pend && !rst_drive) begin
      chk("stall_vld", 64'(m_tvalid), 64'd1);
      chk("stall_dat", 64'(m_tdata), 64'(held_dat));
      chk("stall_last", 64'(m_tlast), 64'(held_last));
    end
    if (m_tvalid && m_tready) begin
      beat_dat.push_back(m_tdata);
      beat_last.push_back(m_tlast);
      beat_cyc.push_back(cyc);
`ifdef STFT_FRAMER_TUSER_EN
      beat_user.push_back(m_tuser);
`endif
    end
    stall_pend = m_tvalid && !m_tready && !rst_drive;
    held_dat   = m_tdata;
    held_last  = m_tlast;
    if (s_tvalid && s_tready) begin
      src_idx++;
      acc_cyc.push_back(cyc);
    end
    cyc++;
  endtask

  task automatic clear_logs();
    beat_dat.delete();
    beat_last.delete();
    beat_cyc.delete();
    acc_cyc.delete();
`ifdef STFT_FRAMER_TUSER_EN
    beat_user.delete();
`endif
    stall_pend = 1'b0;
    cyc        = 0;
  endtask

  // Two reset cycles with no input offered, then cycle counting restarts at 0
  task automatic start_test(input int mode);
    tr_mode   = mode;
    src_q.delete();
    src_idx   = 0;
    rst_drive = 1'b1;
    do_cycle();
    do_cycle();
    rst_drive = 1'b0;
    clear_logs();
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) do_cycle();
  endtask

  initial begin
    reset = 1'b1; s_tvalid = 1'b0; s_tdata = '0; m_tready = 1'b0;
    rst_drive = 1'b1; src_idx = 0; tr_mode = 0; stall_pend = 1'b0; cyc = 0;
    held_dat = '0; held_last = 1'b0;

    // ---- Reset state, then ramp 0..15 with downstream always ready ----
    start_test(0);
    chk("rst_m_tvalid", 64'(smp_vld), 64'd0);
    chk("rst_m_tlast", 64'(smp_last), 64'd0);
    chk("rst_m_tdata", 64'(smp_dat), 64'd0);
    chk("rst_s_tready", 64'(smp_srdy), 64'd0);
    for (int i = 0; i < 16; i++) src_q.push_back(24'(i));
    do_cycle();
    chk("post_rst_s_tready", 64'(smp_srdy), 64'd1);
    run(49);
    chk("t1_beats", 64'(beat_dat.size()), 64'd24);
    for (int i = 0; i < 24; i++) begin
      chk($sformatf("t1_dat%0d", i), 64'(bdat(i)), 64'((i / 8) * 4 + (i % 8)));
      chk($sformatf("t1_last%0d", i), 64'(blast(i)), 64'(i % 8 == 7));
    end
    chk("t1_first_beat_cyc", 64'(bcyc(0)), 64'd10);
    chk("t1_frame0_last_cyc", 64'(bcyc(7)), 64'd17);
    chk("t1_frame1_first_cyc", 64'(bcyc(8)), 64'd21);

    // ---- Same ramp with downstream ready toggling every cycle ----
    start_test(1);
    for (int i = 0; i < 16; i++) src_q.push_back(24'(i));
    run(120);
    chk("t2_beats", 64'(beat_dat.size()), 64'd24);
    for (int i = 0; i < 24; i++) begin
      chk($sformatf("t2_dat%0d", i), 64'(bdat(i)), 64'((i / 8) * 4 + (i % 8)));
      chk($sformatf("t2_last%0d", i), 64'(blast(i)), 64'(i % 8 == 7));
    end

    // ---- Downstream blocked: 20 offered, 16 accepted, resume after first retire ----
    start_test(2);
    for (int i = 0; i < 20; i++) src_q.push_back(24'(200 + i));
    run(30);
    chk("t3_accepted", 64'(src_idx), 64'd16);
    chk("t3_s_tready_full", 64'(smp_srdy), 64'd0);
    chk("t3_held_vld", 64'(smp_vld), 64'd1);
    chk("t3_held_dat", 64'(smp_dat), 64'd200);
    r = cyc;
    tr_mode = 0;
    run(20);
    chk("t3_first_beat_cyc", 64'(bcyc(0)), 64'(r));
    chk("t3_resume_acc_cyc", 64'(acyc(16)), 64'(r + 9));
    chk("t3_accepted_total", 64'(src_idx), 64'd20);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t3_dat%0d", i), 64'(bdat(i)), 64'(200 + i));
    chk("t3_last7", 64'(blast(7)), 64'd1);

    // ---- Reset after the 3rd beat of the first frame, then ramp 100.. ----
    start_test(0);
    for (int i = 0; i < 16; i++) src_q.push_back(24'(i));
    run(13);
    chk("t4_beats_before_rst", 64'(beat_dat.size()), 64'd3);
    rst_drive = 1'b1;
    do_cycle();
    chk("t4_rst_m_tvalid", 64'(smp_vld), 64'd0);
    chk("t4_rst_m_tlast", 64'(smp_last), 64'd0);
    chk("t4_rst_m_tdata", 64'(smp_dat), 64'd0);
    chk("t4_rst_s_tready", 64'(smp_srdy), 64'd0);
    rst_drive = 1'b0;
    clear_logs();
    src_q.delete();
    src_idx = 0;
    for (int i = 0; i < 16; i++) src_q.push_back(24'(100 + i));
    run(20);
    chk("t4_beats", 64'(beat_dat.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t4_dat%0d", i), 64'(bdat(i)), 64'(100 + i));
      chk($sformatf("t4_last%0d", i), 64'(blast(i)), 64'(i == 7));
    end

    // ---- Sign/extreme values pass untouched, imaginary half zero ----
    start_test(0);
    src_q.push_back(24'h800000);
    src_q.push_back(24'hFFFFFF);
    for (int i = 1; i <= 10; i++) src_q.push_back(24'(i));
    run(35);
    chk("t5_beats", 64'(beat_dat.size()), 64'd16);
    chk("t5_min_neg", 64'(bdat(0)), 64'h0000_0000_0080_0000);
    chk("t5_minus_one", 64'(bdat(1)), 64'h0000_0000_00FF_FFFF);
`ifdef STFT_FRAMER_TUSER_EN
    chk("t5_tuser_f0b0", 64'((beat_user.size() > 0) ? beat_user[0] : 16'hxxxx), 64'h0000);
    chk("t5_tuser_f1b3", 64'((beat_user.size() > 11) ? beat_user[11] : 16'hxxxx), 64'h000B);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
